// File: rtl/init_delay_reader.sv
// init_delay_reader: consumer end of the delayed-init register path.
// Waits out the writer's init delay after reset, then captures data_in on a
// four-phase req/ack handshake, counting completed reads modulo 256.
// Optional macro CONST_CHECK_EN: flags any capture that differs from CONST_VAL
// on a sticky mismatch output; when undefined, mismatch is tied low.
module init_delay_reader #(
    parameter int unsigned       WIDTH      = 2,
    parameter logic [WIDTH-1:0]  INIT       = '0,
    parameter int unsigned       INIT_DELAY = 2,
    parameter logic [WIDTH-1:0]  CONST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             req,
    output logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             ready,
    output logic [7:0]       rd_count,
    output logic             mismatch
);

    // A delay of 0 behaves as 1
    localparam int unsigned DLY   = (INIT_DELAY == 0) ? 1 : INIT_DELAY;
    localparam int unsigned CNT_W = (DLY < 2) ? 1 : $clog2(DLY + 1);
    localparam int unsigned RD_W  = 8;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACK       = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  dly_q, dly_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              ack_q, ack_d;
    logic              ready_q, ready_d;
    logic [RD_W-1:0]   rd_q, rd_d;

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_WAIT_INIT;
            dly_q   <= CNT_W'(DLY);
            data_q  <= INIT;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state: init countdown, capture on req, release on req low
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        data_d  = data_q;
        ack_d   = ack_q;
        ready_d = ready_q;
        rd_d    = rd_q;
        case (state_q)
            ST_WAIT_INIT: begin
                dly_d = dly_q - CNT_W'(1);
                if (dly_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    data_d  = data_in;
                    rd_d    = rd_q + RD_W'(1);
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_WAIT_INIT;
                dly_d   = CNT_W'(DLY);
                ack_d   = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign ack      = ack_q;
    assign data_out = data_q;
    assign ready    = ready_q;
    assign rd_count = rd_q;

`ifdef CONST_CHECK_EN
    logic mism_q, mism_d;

    // Sticky compare flag, set on any capture that differs from CONST_VAL
    always_comb begin
        mism_d = mism_q;
        if (state_q == ST_IDLE && req && data_in != CONST_VAL) begin
            mism_d = 1'b1;
        end
    end

    // Compare flag register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mism_q <= 1'b0;
        end else begin
            mism_q <= mism_d;
        end
    end

    assign mismatch = mism_q;
`else
    logic unused_const_val;
    assign unused_const_val = ^CONST_VAL;
    assign mismatch         = 1'b0;
`endif

endmodule
